// File: rtl/modulus_table_writer_if.sv
// Write-side bus of the modulus table writer.
// master: drives wr_valid/wr_addr/wr_data and samples wr_ready.
// slave : the table; drives wr_ready and samples the write request.
interface modulus_table_writer_if #(
    parameter int MODULUS_WIDTH = 1024,
    parameter int ADDR_WIDTH    = 9
);
    logic                     wr_valid;
    logic                     wr_ready;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [MODULUS_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/modulus_table_writer.sv
// Builds a 2**ADDR_WIDTH entry reduction table: entry i = (i*B) mod M, where
// the host supplies B = 2**CUR_LOW_POS mod M. Entries are produced by
// repeated modular addition, one entry per clock while the table accepts.
// Ports:
//   clk_phase - clock, rising edge
//   reset     - asynchronous, active-high
//   start     - one-cycle build request (ignored while busy)
//   modulus   - M, captured on an accepted start
//   base      - B, captured on an accepted start
//   wr        - write bus (wr_valid/wr_ready/wr_addr/wr_data), master side
//   busy      - build in progress (RUN or FINISH)
//   done      - one-cycle pulse when a build ends
//   err       - last build rejected because B >= M; held until next start
module modulus_table_writer #(
    parameter int MODULUS_WIDTH = 1024,
    parameter int ADDR_WIDTH    = 9
) (
    input  logic                     clk_phase,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MODULUS_WIDTH-1:0] modulus,
    input  logic [MODULUS_WIDTH-1:0] base,
    modulus_table_writer_if.master   wr,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t                   state;
    logic [MODULUS_WIDTH-1:0] m_q;
    logic [MODULUS_WIDTH-1:0] b_q;
    logic [MODULUS_WIDTH-1:0] acc;
    logic [ADDR_WIDTH-1:0]    idx;
    logic                     valid_q;

    logic [MODULUS_WIDTH:0]   sum;
    logic [MODULUS_WIDTH-1:0] acc_next;
    logic                     last;

    // acc < M and B < M, so sum < 2M and one conditional subtract keeps
    // acc_next < M. The subtraction may wrap in the low bits; the true
    // result is below M so the truncated value is exact.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, b_q};
        acc_next = sum[MODULUS_WIDTH-1:0];
        if (sum >= {1'b0, m_q}) begin
            acc_next = sum[MODULUS_WIDTH-1:0] - m_q;
        end
        last = (idx == '1);
    end

    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = idx;
    assign wr.wr_data  = acc;

    always_ff @(posedge clk_phase or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            m_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            idx     <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q  <= modulus;
                        b_q  <= base;
                        acc  <= '0;
                        idx  <= '0;
                        busy <= 1'b1;
                        if (base >= modulus) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            err     <= 1'b0;
                            valid_q <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (valid_q && wr.wr_ready) begin
                        acc <= acc_next;
                        // idx stays at the last address on the final
                        // transfer so it never wraps inside a build.
                        if (last) begin
                            valid_q <= 1'b0;
                            done    <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            idx <= idx + ADDR_WIDTH'(1);
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/modulus_table_writer.md
MODULUS_TABLE_WRITER -- requirements
Module: modulus_table_writer

Interface
REQ-001 SHALL have parameter MODULUS_WIDTH, default 1024, giving the modulus and table-entry width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, giving the table depth as 2**ADDR_WIDTH entries.
REQ-003 SHALL have port clk_phase, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to build the table.
REQ-006 SHALL have port modulus, input, MODULUS_WIDTH bits: reduction modulus M, sampled when start is accepted.
REQ-007 SHALL have port base, input, MODULUS_WIDTH bits: B = 2**CUR_LOW_POS mod M, host-precomputed and sampled when start is accepted.
REQ-008 SHALL have port wr_valid, output, 1 bit: table write request.
REQ-009 SHALL have port wr_ready, input, 1 bit: the table accepts the write this cycle.
REQ-010 SHALL have port wr_addr, output, ADDR_WIDTH bits: table index i.
REQ-011 SHALL have port wr_data, output, MODULUS_WIDTH bits: the value (i*B) mod M.
REQ-012 SHALL have port busy, output, 1 bit: a build is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a build ends.
REQ-014 SHALL have port err, output, 1 bit: the last build was rejected; held until the next accepted start.

Function
REQ-015 SHALL implement the states IDLE, RUN and FINISH.
REQ-016 In IDLE, start=1 SHALL capture M and B, set acc=0 and idx=0, and go to RUN; if B>=M (this includes M=0) it SHALL instead set err=1 and go to FINISH without issuing any write.
REQ-017 In RUN, wr_valid SHALL be 1 with wr_addr=idx and wr_data=acc.
REQ-018 A write SHALL transfer only on a cycle with wr_valid=1 and wr_ready=1.
REQ-019 While wr_ready=0, wr_addr and wr_data SHALL hold stable; there is no timeout.
REQ-020 On each transfer, the block SHALL compute s=acc+B over MODULUS_WIDTH+1 bits and set acc = s-M if s>=M, else s; idx SHALL increment by one.
REQ-021 The transfer at idx = 2**ADDR_WIDTH-1 SHALL end the build and go to FINISH; idx SHALL NOT wrap within a build.
REQ-022 Sustained throughput with wr_ready held at 1 SHALL be one entry per clock.
REQ-023 The first write SHALL be presented in the cycle after start is accepted.
REQ-024 FINISH SHALL last one cycle, assert done=1, and return to IDLE.
REQ-025 busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 Changes to modulus or base during a build SHALL have no effect.
REQ-028 An accepted start with B<M SHALL clear err.
REQ-029 The accumulator SHALL satisfy acc<M at all times after capture.
REQ-030 The entries written SHALL be bit-identical to (i << CUR_LOW_POS) mod M for every i, so the table can replace a fixed, init-time reduction table.

Reset
REQ-031 reset=1 SHALL immediately force state=IDLE, wr_valid=0, busy=0, done=0, err=0, wr_addr=0, wr_data=0, acc=0 and idx=0, without waiting for a clock edge.
REQ-032 A reset during RUN SHALL abandon the build; table contents are then undefined until a new build completes.
REQ-033 After reset deasserts, the first accepted start SHALL begin a clean build.

Verification
REQ-034 Scenario with MODULUS_WIDTH=16, ADDR_WIDTH=3, M=1009, B=600 and wr_ready=1:
- writes are (0,0), (1,600), (2,191), (3,791), (4,382), (5,982), (6,573), (7,164) on 8 consecutive cycles;
- done pulses in the cycle after the last write.
REQ-035 Scenario as REQ-034 but with wr_ready=0 for 3 cycles during idx 2:
- addr 2 / data 191 is held for 4 cycles;
- the sequence is otherwise unchanged;
- done is delayed by exactly 3 cycles.
REQ-036 Scenario with M=1009 and B=1009: err=1, done pulses one cycle after start, and wr_valid is never asserted.
REQ-037 Scenario with start pulsed again at idx 4 and modulus changed at the same time: the pulse is ignored and the output still matches REQ-034.
REQ-038 Scenario with reset asserted mid-cycle at idx 5: wr_valid, busy and acc are 0 before the next clock edge; a subsequent start reproduces REQ-034 exactly.
REQ-039 Randomized check at default parameters: the sequence for random M (odd, MSB set) and B<M matches the reference model (i*B) mod M for all 512 entries.
